opsum_requant_packer: RTL and testbench

- Sits directly downstream of the PE array opsum port.
- Consumes 32-bit signed partial sums, one output channel value per handshake, and requantizes each to int8: bias add, scale multiply, rounding right shift, zero-point add, optional ReLU, clamp.
- Packs four results per 32-bit word in offset-binary format (int8 XOR 0x80), the same byte format the PE ifmap loader expects, so words go straight back to the GLB as the next layer's ifmap.

---
 rtl/opsum_requant_packer.sv | 216 +++++++++++++++++++++
 tb/tb_opsum_requant_packer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opsum_requant_packer.sv
// opsum_requant_packer
// Requantizes 32-bit signed partial sums to int8 (bias, scale, rounding
// shift, zero point, optional ReLU, clamp) and packs four offset-binary
// bytes per output word, ready to be written back as the next layer's ifmap.
// The pipeline is: input register -> S1 (bias add) -> S2 (scale multiply)
// -> S3 (round/zp/clamp to byte) -> packer -> output register.
// A single stall enable freezes every stage while an output word waits.

module opsum_requant_packer #(
  parameter int DATA_BITS  = 32,
  parameter int SCALE_BITS = 16,
  parameter int SHIFT_BITS = 5,
  parameter int LANES      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_load,
  input  logic [31:0]           cfg_bias,
  input  logic [SCALE_BITS-1:0] cfg_scale,
  input  logic [SHIFT_BITS-1:0] cfg_shift,
  input  logic [7:0]            cfg_zp,
  input  logic                  cfg_relu,
  output logic                  busy,
  input  logic [DATA_BITS-1:0]  psum,
  input  logic                  psum_valid,
  input  logic                  psum_last,
  output logic                  psum_ready,
  output logic [DATA_BITS-1:0]  out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready
);

  localparam int ACC_W  = DATA_BITS + 1;
  localparam int PROD_W = ACC_W + SCALE_BITS;
  localparam int RND_W  = PROD_W + 2;
  localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;

  // Configuration registers
  logic signed [31:0]           bias_r;
  logic signed [SCALE_BITS-1:0] scale_r;
  logic [SHIFT_BITS-1:0]        shift_r;
  logic signed [7:0]            zp_r;
  logic                         relu_r;

  // Pipeline registers
  logic                         in_valid_r, in_last_r;
  logic signed [DATA_BITS-1:0]  in_psum_r;
  logic                         s1_valid_r, s1_last_r;
  logic signed [ACC_W-1:0]      s1_acc_r;
  logic                         s2_valid_r, s2_last_r;
  logic signed [PROD_W-1:0]     s2_prod_r;
  logic                         s3_valid_r, s3_last_r;
  logic [7:0]                   s3_byte_r;

  // Packer state
  logic [DATA_BITS-1:0]         pack_r;
  logic [CNT_W-1:0]             cnt_r;

  // Combinational helpers
  logic                         en;
  logic                         accept;
  logic signed [ACC_W-1:0]      acc_next;
  logic signed [PROD_W-1:0]     prod_next;
  logic signed [RND_W-1:0]      rnd_add, rnd_sum, rnd_val, y_val, lo_val, hi_val, q_val;
  logic [7:0]                   byte_next;
  logic [DATA_BITS-1:0]         pack_next;
  logic                         word_done;

  assign en         = !out_valid || out_ready;
  assign psum_ready = en;
  assign accept     = psum_valid && en;
  assign busy       = in_valid_r || s1_valid_r || s2_valid_r || s3_valid_r ||
                      (cnt_r != '0) || out_valid;

  // Bias add and exact scale multiply feeding S1 and S2
  always_comb begin
    acc_next  = ACC_W'(in_psum_r) + ACC_W'(bias_r);
    prod_next = PROD_W'(s1_acc_r) * PROD_W'(scale_r);
  end

  // Round-half-up shift, zero point add and clamp into an offset-binary byte
  always_comb begin
    rnd_add = '0;
    if (shift_r == '0) begin
      rnd_add = '0;
    end else begin
      rnd_add = RND_W'(64'sd1) <<< (shift_r - SHIFT_BITS'(1));
    end
    rnd_sum = RND_W'(s2_prod_r) + rnd_add;
    rnd_val = rnd_sum >>> shift_r;
    y_val   = rnd_val + RND_W'(zp_r);
    hi_val  = RND_W'(8'sh7f);
    if (relu_r) begin
      lo_val = RND_W'(zp_r);
    end else begin
      lo_val = RND_W'(8'sh80);
    end
    if (y_val < lo_val) begin
      q_val = lo_val;
    end else if (y_val > hi_val) begin
      q_val = hi_val;
    end else begin
      q_val = y_val;
    end
    byte_next = q_val[7:0] ^ 8'h80;
  end

  // Insert the S3 byte into the current lane and decide whether the word closes
  always_comb begin
    pack_next = pack_r;
    for (int k = 0; k < LANES; k++) begin
      if (cnt_r == CNT_W'(k)) begin
        pack_next[8*k +: 8] = s3_byte_r;
      end else begin
        pack_next[8*k +: 8] = pack_r[8*k +: 8];
      end
    end
    word_done = s3_valid_r && ((cnt_r == CNT_W'(LANES - 1)) || s3_last_r);
  end

  // Latch configuration only while the datapath is empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bias_r  <= 32'sd0;
      scale_r <= SCALE_BITS'(1);
      shift_r <= '0;
      zp_r    <= 8'sd0;
      relu_r  <= 1'b0;
    end else if (cfg_load && !busy) begin
      bias_r  <= cfg_bias;
      scale_r <= cfg_scale;
      shift_r <= cfg_shift;
      zp_r    <= cfg_zp;
      relu_r  <= cfg_relu;
    end else begin
      bias_r  <= bias_r;
      scale_r <= scale_r;
      shift_r <= shift_r;
      zp_r    <= zp_r;
      relu_r  <= relu_r;
    end
  end

  // Advance the requant pipeline one stage whenever the output is not stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_valid_r <= 1'b0;
      in_last_r  <= 1'b0;
      in_psum_r  <= '0;
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_acc_r   <= '0;
      s2_valid_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_prod_r  <= '0;
      s3_valid_r <= 1'b0;
      s3_last_r  <= 1'b0;
      s3_byte_r  <= 8'h80;
    end else if (en) begin
      in_valid_r <= accept;
      in_last_r  <= psum_last;
      in_psum_r  <= psum;
      s1_valid_r <= in_valid_r;
      s1_last_r  <= in_last_r;
      s1_acc_r   <= acc_next;
      s2_valid_r <= s1_valid_r;
      s2_last_r  <= s1_last_r;
      s2_prod_r  <= prod_next;
      s3_valid_r <= s2_valid_r;
      s3_last_r  <= s2_last_r;
      s3_byte_r  <= byte_next;
    end else begin
      in_valid_r <= in_valid_r;
      in_last_r  <= in_last_r;
      in_psum_r  <= in_psum_r;
      s1_valid_r <= s1_valid_r;
      s1_last_r  <= s1_last_r;
      s1_acc_r   <= s1_acc_r;
      s2_valid_r <= s2_valid_r;
      s2_last_r  <= s2_last_r;
      s2_prod_r  <= s2_prod_r;
      s3_valid_r <= s3_valid_r;
      s3_last_r  <= s3_last_r;
      s3_byte_r  <= s3_byte_r;
    end
  end

  // Pack bytes into lanes and hand completed words to the output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pack_r    <= {LANES{8'h80}};
      cnt_r     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (en && s3_valid_r) begin
      if (word_done) begin
        out_data  <= pack_next;
        out_valid <= 1'b1;
        out_last  <= s3_last_r;
        cnt_r     <= '0;
        pack_r    <= {LANES{8'h80}};
      end else begin
        pack_r    <= pack_next;
        cnt_r     <= cnt_r + CNT_W'(1);
        out_valid <= out_valid && !out_ready;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_opsum_requant_packer.sv
// Scoreboard bench for opsum_requant_packer: stimulus pushes expected words,
// an independent monitor pops and compares on every output handshake.

module tb_opsum_requant_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_load = 1'b0;
  logic [31:0] cfg_bias = 32'd0;
  logic [15:0] cfg_scale = 16'd1;
  logic [4:0]  cfg_shift = 5'd0;
  logic [7:0]  cfg_zp = 8'd0;
  logic        cfg_relu = 1'b0;
  logic        busy;
  logic [31:0] psum = 32'd0;
  logic        psum_valid = 1'b0;
  logic        psum_last = 1'b0;
  logic        psum_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b1;

  int n_cmp = 0;
  int n_fail = 0;

  logic [32:0] exp_q[$];
  logic [7:0]  m_lanes[$];
  longint      m_bias = 0;
  longint      m_scale = 1;
  int          m_shift = 0;
  longint      m_zp = 0;
  bit          m_relu = 1'b0;

  bit rnd_ready = 1'b0;
  int bp_req = 0;
  int bp_seen = 0;
  int bp_hold = 0;
  int ready_low = 0;

  opsum_requant_packer dut (
    .clk(clk), .rst(rst),
    .cfg_load(cfg_load), .cfg_bias(cfg_bias), .cfg_scale(cfg_scale),
    .cfg_shift(cfg_shift), .cfg_zp(cfg_zp), .cfg_relu(cfg_relu),
    .busy(busy),
    .psum(psum), .psum_valid(psum_valid), .psum_last(psum_last), .psum_ready(psum_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: requantize one psum with plain integer arithmetic
  function automatic logic [7:0] ref_byte(input logic [31:0] p);
    longint acc, prod, r, y, lo, q;
    logic [7:0] b;
    acc  = longint'($signed(p)) + m_bias;
    prod = acc * m_scale;
    if (m_shift == 0) r = prod;
    else r = (prod + (64'sd1 <<< (m_shift - 1))) >>> m_shift;
    y  = r + m_zp;
    lo = m_relu ? m_zp : -64'sd128;
    q  = y;
    if (q < lo) q = lo;
    if (q > 64'sd127) q = 64'sd127;
    b = 8'(q);
    return b ^ 8'h80;
  endfunction

  // Reference packing: collect bytes, close a word on 4 lanes or a last tag
  function automatic void model_push(input logic [31:0] p, input logic last);
    logic [31:0] w;
    m_lanes.push_back(ref_byte(p));
    if (m_lanes.size() == 4 || last) begin
      w = 32'h80808080;
      for (int i = 0; i < m_lanes.size(); i++) w[8*i +: 8] = m_lanes[i];
      exp_q.push_back({last, w});
      m_lanes.delete();
    end
  endfunction

  function automatic void model_reset();
    m_lanes.delete();
    m_bias = 0; m_scale = 1; m_shift = 0; m_zp = 0; m_relu = 1'b0;
  endfunction

  task automatic send(input logic [31:0] p, input logic last, input bit use_model);
    bit ok;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      psum = p; psum_last = last; psum_valid = 1'b1;
      #1 ok = psum_ready;
      @(posedge clk);
      if (ok) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: got no accept expected accept for psum %0h", p);
    end else if (use_model) begin
      model_push(p, last);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      psum_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    @(negedge clk);
    psum_valid = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      #1;
      if (busy == 1'b0 && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout: got busy=%0d pending=%0d expected 0 0", busy, exp_q.size());
    end
  endtask

  task automatic do_cfg(input longint b, input longint sc, input int sh, input longint zp, input bit relu);
    wait_idle();
    @(negedge clk);
    cfg_bias = 32'(b); cfg_scale = 16'(sc); cfg_shift = 5'(sh);
    cfg_zp = 8'(zp); cfg_relu = relu; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    m_bias = b; m_scale = sc; m_shift = sh; m_zp = zp; m_relu = relu;
  endtask

  // Downstream ready: always, random, or a one-shot 6-cycle stall
  always @(negedge clk) begin
    if (bp_hold > 0) begin
      out_ready = 1'b0;
      bp_hold--;
    end else if (bp_req != bp_seen && out_valid === 1'b1) begin
      bp_seen = bp_req;
      out_ready = 1'b0;
      bp_hold = 5;
    end else if (rnd_ready) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor: compare every transferred word and stability while stalled
  logic [32:0] held;
  bit          stall_pending = 1'b0;
  always @(negedge clk) begin
    logic [32:0] e;
    #2;
    if (!psum_ready) ready_low++;
    if (rst && out_valid) begin
      if (stall_pending) check("stall_stable", {31'd0, out_last, out_data}, {31'd0, held});
      if (out_ready) begin
        stall_pending = 1'b0;
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {32'd0, out_data}, {32'd0, e[31:0]});
          check("out_last", {63'd0, out_last}, {63'd0, e[32]});
        end
      end else begin
        stall_pending = 1'b1;
        held = {out_last, out_data};
      end
    end else begin
      stall_pending = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lo_before;
    logic [31:0] p;
    logic [15:0] sc16;
    logic [31:0] b32;
    logic [7:0]  zp8;

    // Reset state
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_out_last", {63'd0, out_last}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rst_psum_ready", {63'd0, psum_ready}, 64'd1);

    // Identity with latency check
    exp_q.push_back({1'b0, 32'h00FF7F81});
    send(32'd1, 1'b0, 1'b0);
    send(32'hFFFFFFFF, 1'b0, 1'b0);
    send(32'd127, 1'b0, 1'b0);
    send(32'hFFFFFF80, 1'b0, 1'b0);
    @(negedge clk);
    psum_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("latency_t3", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1 check("latency_t4", {63'd0, out_valid}, 64'd1);
    wait_idle();

    // Partial flush, then backpressure stream starting at lane 0
    exp_q.push_back({1'b1, 32'h80808987});
    send(32'd7, 1'b0, 1'b0);
    send(32'd9, 1'b1, 1'b0);
    exp_q.push_back({1'b0, 32'h83828180});
    exp_q.push_back({1'b0, 32'h87868584});
    exp_q.push_back({1'b0, 32'h8B8A8988});
    lo_before = ready_low;
    bp_req++;
    for (int i = 0; i < 12; i++) send(32'(i), 1'b0, 1'b0);
    wait_idle();
    check("bp_ready_dropped", {63'd0, (ready_low - lo_before) >= 5}, 64'd1);

    // Rounding
    do_cfg(0, 3, 2, 0, 1'b0);
    exp_q.push_back({1'b1, 32'h80827C84});
    send(32'd5, 1'b0, 1'b0);
    send(32'hFFFFFFFB, 1'b0, 1'b0);
    send(32'd2, 1'b0, 1'b0);
    send(32'd0, 1'b1, 1'b0);

    // Saturation and ReLU
    do_cfg(0, 1, 0, 0, 1'b0);
    exp_q.push_back({1'b1, 32'h808000FF});
    send(32'd1000, 1'b0, 1'b0);
    send(32'hFFFFFC18, 1'b1, 1'b0);
    do_cfg(0, 1, 0, 0, 1'b1);
    exp_q.push_back({1'b1, 32'h80808080});
    send(32'hFFFFFC18, 1'b1, 1'b0);
    do_cfg(-10, 1, 0, 5, 1'b1);
    exp_q.push_back({1'b1, 32'h80808085});
    send(32'd0, 1'b1, 1'b0);

    // cfg_load while busy is ignored
    do_cfg(0, 1, 0, 0, 1'b0);
    exp_q.push_back({1'b0, 32'hA89E948A});
    send(32'd10, 1'b0, 1'b0);
    send(32'd20, 1'b0, 1'b0);
    @(negedge clk);
    psum_valid = 1'b0;
    cfg_scale = 16'd2; cfg_load = 1'b1;
    #1 check("cfg_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    cfg_load = 1'b0;
    send(32'd30, 1'b0, 1'b0);
    send(32'd40, 1'b0, 1'b0);

    // Reset mid-word also restores default config
    do_cfg(0, 3, 0, 0, 1'b0);
    send(32'd5, 1'b0, 1'b1);
    send(32'd6, 1'b0, 1'b1);
    @(negedge clk);
    psum_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back({1'b0, 32'h84838281});
    for (int i = 1; i <= 4; i++) send(32'(i), 1'b0, 1'b0);
    wait_idle();

    // Randomized epochs against the reference model, random backpressure
    rnd_ready = 1'b1;
    for (int ep = 0; ep < 8; ep++) begin
      sc16 = 16'($urandom);
      b32  = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : 32'($urandom);
      zp8  = 8'($urandom);
      if (ep == 0) sc16 = 16'd1;
      do_cfg(longint'($signed(b32)), longint'($signed(sc16)),
             (ep == 0) ? 0 : int'($urandom_range(0, 31)),
             longint'($signed(zp8)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 40; i++) begin
        p = ($urandom_range(0, 2) == 0) ? 32'($urandom) : 32'($signed(10'($urandom)));
        send(p, ($urandom_range(0, 5) == 0), 1'b1);
        if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
      end
      send(32'($urandom), 1'b1, 1'b1);
    end
    wait_idle();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
